// File: rtl/scs8hd_o21ai_bist_ctrl.sv
// Self-test sequencer for one o21ai cell: walks all 8 input vectors, samples Y, counts mismatches.
// Optional FAIL_MAP_EN macro adds a sticky per-vector FAILMAP output.
module scs8hd_o21ai_bist_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4,
    parameter int LOOPS         = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    output logic             A1_O,
    output logic             A2_O,
    output logic             B1_O,
    input  logic             Y_I,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERRCNT,
    output logic [2:0]       VEC
`ifdef FAIL_MAP_EN
    ,
    output logic [7:0]       FAILMAP
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LOOP_LAST     = 8'(LOOPS - 1);

    state_t           state_q, state_n;
    logic [3:0]       settle_q, settle_n;
    logic [7:0]       loop_q, loop_n;
    logic [2:0]       vec_q, vec_n;
    logic [ERR_W-1:0] errcnt_q, errcnt_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             pass_q, pass_n;
    logic [7:0]       failmap_q, failmap_n;
    logic             exp_y;
    logic             mismatch;

    assign exp_y    = ~((vec_q[0] | vec_q[1]) & vec_q[2]);
    // Case inequality so an X/Z on the cell output is treated as a failure.
    assign mismatch = (Y_I !== exp_y);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            loop_q    <= '0;
            vec_q     <= '0;
            errcnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            failmap_q <= '0;
        end else begin
            state_q   <= state_n;
            settle_q  <= settle_n;
            loop_q    <= loop_n;
            vec_q     <= vec_n;
            errcnt_q  <= errcnt_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            pass_q    <= pass_n;
            failmap_q <= failmap_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        settle_n  = settle_q;
        loop_n    = loop_q;
        vec_n     = vec_q;
        errcnt_n  = errcnt_q;
        busy_n    = busy_q;
        done_n    = done_q;
        pass_n    = pass_q;
        failmap_n = failmap_q;

        case (state_q)
            IDLE, FINISH: begin
                if (START) begin
                    errcnt_n  = '0;
                    vec_n     = '0;
                    loop_n    = '0;
                    done_n    = 1'b0;
                    pass_n    = 1'b0;
                    busy_n    = 1'b1;
                    failmap_n = '0;
                    settle_n  = SETTLE_RELOAD;
                    state_n   = SETTLE;
                end else if (state_q == FINISH) begin
                    // Result flags land one edge after entering FINISH, using the final count.
                    busy_n = 1'b0;
                    done_n = 1'b1;
                    pass_n = (errcnt_q == '0);
                    vec_n  = '0;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_n = SAMPLE;
                end else begin
                    settle_n = settle_q - 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    failmap_n[vec_q] = 1'b1;
                    if (!(&errcnt_q)) begin
                        errcnt_n = errcnt_q + 1'b1;
                    end
                end
                if (vec_q != 3'd7) begin
                    vec_n    = vec_q + 3'd1;
                    settle_n = SETTLE_RELOAD;
                    state_n  = SETTLE;
                end else if (loop_q != LOOP_LAST) begin
                    loop_n   = loop_q + 8'd1;
                    vec_n    = '0;
                    settle_n = SETTLE_RELOAD;
                    state_n  = SETTLE;
                end else begin
                    state_n = FINISH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign A1_O   = vec_q[0];
    assign A2_O   = vec_q[1];
    assign B1_O   = vec_q[2];
    assign VEC    = vec_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign PASS   = pass_q;
    assign ERRCNT = errcnt_q;

`ifdef FAIL_MAP_EN
    assign FAILMAP = failmap_q;
`else
    logic unused_failmap;
    assign unused_failmap = ^failmap_q;
`endif

endmodule

// File: tb/tb_scs8hd_o21ai_bist_ctrl.sv
// Directed self-checking bench for scs8hd_o21ai_bist_ctrl (default and LOOPS=8 instances).
module tb_scs8hd_o21ai_bist_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       START = 1'b0;
    logic       START8 = 1'b0;
    logic       A1_O, A2_O, B1_O, Y_I;
    logic       BUSY, DONE, PASS;
    logic [3:0] ERRCNT;
    logic [2:0] VEC;
    logic       a1_8, a2_8, b1_8, busy_8, done_8, pass_8;
    logic [3:0] errcnt_8;
    logic [2:0] vec_8;
    int         y_mode = 0;
    int         checks = 0;
    int         errors = 0;
`ifdef FAIL_MAP_EN
    logic [7:0] FAILMAP, failmap_8;
`endif

    always #5 CLK = ~CLK;

    // Cell model: 0 = healthy o21ai, 1 = stuck at 0, 2 = stuck at 1.
    always_comb begin
        Y_I = ~((A1_O | A2_O) & B1_O);
        if (y_mode == 1) Y_I = 1'b0;
        if (y_mode == 2) Y_I = 1'b1;
    end

    scs8hd_o21ai_bist_ctrl dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .A1_O(A1_O), .A2_O(A2_O), .B1_O(B1_O), .Y_I(Y_I),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERRCNT(ERRCNT), .VEC(VEC)
`ifdef FAIL_MAP_EN
        , .FAILMAP(FAILMAP)
`endif
    );

    scs8hd_o21ai_bist_ctrl #(.SETTLE_CYCLES(2), .ERR_W(4), .LOOPS(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .START(START8),
        .A1_O(a1_8), .A2_O(a2_8), .B1_O(b1_8), .Y_I(1'b0),
        .BUSY(busy_8), .DONE(done_8), .PASS(pass_8), .ERRCNT(errcnt_8), .VEC(vec_8)
`ifdef FAIL_MAP_EN
        , .FAILMAP(failmap_8)
`endif
    );

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic wait_done(output int edge_n);
        edge_n = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) begin
                edge_n = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        #1;
        checks++;
        if ({A1_O, A2_O, B1_O, BUSY, DONE, PASS, ERRCNT, VEC} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, want 0", {A1_O, A2_O, B1_O, BUSY, DONE, PASS, ERRCNT, VEC});
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_correct_cell();
        int edge_n;
        int exp_vec;
        y_mode = 0;
        pulse_start();
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0 || VEC !== 3'd0) begin
            errors++;
            $display("[TB] FAIL start_accept: busy=%b done=%b vec=%0d, want 1 0 0", BUSY, DONE, VEC);
        end
        edge_n = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge CLK);
            #1;
            if (n < 24) begin
                exp_vec = n / 3;
                checks++;
                if (VEC !== 3'(exp_vec) || {B1_O, A2_O, A1_O} !== 3'(exp_vec)) begin
                    errors++;
                    $display("[TB] FAIL vec_hold edge %0d: vec=%0d drives=%b, want %0d", n, VEC, {B1_O, A2_O, A1_O}, exp_vec);
                end
            end
            if (DONE === 1'b1) begin
                edge_n = n;
                break;
            end
        end
        checks++;
        if (edge_n != 25) begin
            errors++;
            $display("[TB] FAIL done_latency: edge %0d, want 25", edge_n);
        end
        checks++;
        if (PASS !== 1'b1 || ERRCNT !== 4'd0 || BUSY !== 1'b0 || VEC !== 3'd0) begin
            errors++;
            $display("[TB] FAIL good_result: pass=%b err=%0d busy=%b vec=%0d, want 1 0 0 0", PASS, ERRCNT, BUSY, VEC);
        end
    endtask

    task automatic test_stuck(input int mode, input logic [3:0] exp_err, input logic [7:0] exp_map);
        int edge_n;
        y_mode = mode;
        pulse_start();
        wait_done(edge_n);
        checks++;
        if (edge_n != 25 || ERRCNT !== exp_err || PASS !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck%0d: edge=%0d err=%0d pass=%b, want 25 %0d 0", mode - 1, edge_n, ERRCNT, PASS, exp_err);
        end
`ifdef FAIL_MAP_EN
        checks++;
        if (FAILMAP !== exp_map) begin
            errors++;
            $display("[TB] FAIL failmap_stuck%0d: got %h, want %h", mode - 1, FAILMAP, exp_map);
        end
`else
        if (exp_map == 8'hxx) $display("[TB] unreachable");
`endif
        y_mode = 0;
    endtask

    task automatic test_saturate();
        int edge_n;
        @(negedge CLK);
        START8 = 1'b1;
        @(posedge CLK);
        #1;
        START8 = 1'b0;
        edge_n = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge CLK);
            #1;
            if (done_8 === 1'b1) begin
                edge_n = n;
                break;
            end
        end
        checks++;
        if (edge_n != 193) begin
            errors++;
            $display("[TB] FAIL loops8_latency: edge %0d, want 193", edge_n);
        end
        checks++;
        if (errcnt_8 !== 4'd15 || pass_8 !== 1'b0 || busy_8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loops8_saturate: err=%0d pass=%b busy=%b, want 15 0 0", errcnt_8, pass_8, busy_8);
        end
`ifdef FAIL_MAP_EN
        checks++;
        if (failmap_8 !== 8'h1F) begin
            errors++;
            $display("[TB] FAIL loops8_failmap: got %h, want 1f", failmap_8);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        int edge_n;
        bit seen;
        y_mode = 1;
        pulse_start();
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge CLK);
            #1;
            if (VEC === 3'd3) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL reach_vec3: vec=%0d, want 3", VEC);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({A1_O, A2_O, B1_O, BUSY, DONE, PASS, ERRCNT, VEC} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_midrun: got %b, want 0", {A1_O, A2_O, B1_O, BUSY, DONE, PASS, ERRCNT, VEC});
        end
        @(negedge CLK);
        RESET = 1'b0;
        y_mode = 0;
        pulse_start();
        wait_done(edge_n);
        checks++;
        if (edge_n != 25 || PASS !== 1'b1 || ERRCNT !== 4'd0) begin
            errors++;
            $display("[TB] FAIL rerun_after_reset: edge=%0d pass=%b err=%0d, want 25 1 0", edge_n, PASS, ERRCNT);
        end
    endtask

    task automatic test_back_to_back();
        int edge_n;
        y_mode = 2;
        pulse_start();
        edge_n = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge CLK);
            #1;
            START = (n == 4 || n == 9);
            if (DONE === 1'b1) begin
                edge_n = n;
                break;
            end
        end
        START = 1'b0;
        checks++;
        if (edge_n != 25 || ERRCNT !== 4'd3) begin
            errors++;
            $display("[TB] FAIL start_ignored: edge=%0d err=%0d, want 25 3", edge_n, ERRCNT);
        end
        y_mode = 0;
        pulse_start();
        checks++;
        if (DONE !== 1'b0 || PASS !== 1'b0 || BUSY !== 1'b1 || ERRCNT !== 4'd0) begin
            errors++;
            $display("[TB] FAIL restart_from_finish: done=%b pass=%b busy=%b err=%0d, want 0 0 1 0", DONE, PASS, BUSY, ERRCNT);
        end
        wait_done(edge_n);
        checks++;
        if (edge_n != 25 || PASS !== 1'b1) begin
            errors++;
            $display("[TB] FAIL second_run: edge=%0d pass=%b, want 25 1", edge_n, PASS);
        end
    endtask

    initial begin
        test_reset();
        test_correct_cell();
        test_stuck(1, 4'd5, 8'h1F);
        test_stuck(2, 4'd3, 8'hE0);
        test_saturate();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
